// File: rtl/tx_payload_loader.sv
`default_nettype none
// =============================================================================
// Module   : tx_payload_loader
// Brief    : Writes a valid/ready/last payload stream into the TX async FIFO,
//            pads short frames (TX_LOADER_PAD_EN), truncates oversize frames
//            and limits queued frames via pct_qued/pct_txed accounting.
// Revision : 1.0 - initial release
// =============================================================================
module tx_payload_loader #(
    parameter int WIDTH    = 8,
    parameter int MIN_LEN  = 46,
    parameter int MAX_LEN  = 1500,
    parameter int MAX_PKTS = 2,
    parameter int LEN_W    = 11
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             buf_full,
    input  logic             pct_txed,
    output logic [WIDTH-1:0] data_out,
    output logic             buf_w_en,
    output logic             pct_qued,
    output logic [LEN_W-1:0] pct_len,
    output logic             err_oversize
);

    localparam int                  c_pend_w   = $clog2(MAX_PKTS + 1);
    localparam logic [LEN_W-1:0]    c_min_len  = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0]    c_max_len  = LEN_W'(MAX_LEN);
    localparam logic [c_pend_w-1:0] c_max_pkts = c_pend_w'(MAX_PKTS);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_pad   = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

`ifdef TX_LOADER_PAD_EN
    localparam logic c_pad_en = 1'b1;
`else
    localparam logic c_pad_en = 1'b0;
`endif

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [LEN_W-1:0]    r_byte_cnt;
    logic [LEN_W-1:0]    w_byte_cnt_nxt;
    logic [LEN_W-1:0]    w_cnt_inc;
    logic                r_oversize;
    logic                w_oversize_nxt;
    logic [c_pend_w-1:0] r_pend_cnt;
    logic                r_run;
    logic                w_ready_raw;
    logic                w_accept;
    logic                w_short;
    logic                w_wr_en;
    logic [WIDTH-1:0]    w_wr_data;
    logic                w_done_fire;
    logic                w_pend_dec;

    assign w_cnt_inc  = r_byte_cnt + LEN_W'(1);
    assign w_short    = w_cnt_inc < c_min_len;
    assign w_accept   = s_valid & s_ready;
    assign w_pend_dec = pct_txed && (r_pend_cnt != '0);

    // r_run keeps s_ready low while reset is held and for the first cycle out
    always_comb begin
        w_ready_raw = 1'b0;
        case (r_state)
            c_st_idle:  w_ready_raw = !buf_full && (r_pend_cnt < c_max_pkts);
            c_st_load:  w_ready_raw = !buf_full;
            c_st_drain: w_ready_raw = 1'b1;
            default:    w_ready_raw = 1'b0;
        endcase
    end

    assign s_ready = w_ready_raw & r_run;

    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_oversize_nxt = r_oversize;
        w_wr_en        = 1'b0;
        w_wr_data      = s_data;
        w_done_fire    = 1'b0;
        case (r_state)
            // IDLE has byte_cnt=0, so it shares the LOAD accept path
            c_st_idle, c_st_load: begin
                if (w_accept) begin
                    w_wr_en        = 1'b1;
                    w_byte_cnt_nxt = w_cnt_inc;
                    if (s_last) begin
                        w_state_nxt = (w_short && c_pad_en) ? c_st_pad : c_st_done;
                    end else if (w_cnt_inc == c_max_len) begin
                        w_state_nxt    = c_st_drain;
                        w_oversize_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_st_load;
                    end
                end
            end
`ifdef TX_LOADER_PAD_EN
            c_st_pad: begin
                if (!buf_full) begin
                    w_wr_en        = 1'b1;
                    w_wr_data      = '0;
                    w_byte_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_min_len) begin
                        w_state_nxt = c_st_done;
                    end
                end
            end
`endif
            c_st_drain: begin
                if (w_accept && s_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            // First DONE cycle launches pct_qued, second one clears and exits
            c_st_done: begin
                if (pct_qued) begin
                    w_state_nxt    = c_st_idle;
                    w_byte_cnt_nxt = '0;
                    w_oversize_nxt = 1'b0;
                end else begin
                    w_done_fire = 1'b1;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= c_st_idle;
            r_byte_cnt   <= '0;
            r_oversize   <= 1'b0;
            r_pend_cnt   <= '0;
            r_run        <= 1'b0;
            data_out     <= '0;
            buf_w_en     <= 1'b0;
            pct_qued     <= 1'b0;
            pct_len      <= '0;
            err_oversize <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_oversize   <= w_oversize_nxt;
            buf_w_en     <= w_wr_en;
            if (w_wr_en) begin
                data_out <= w_wr_data;
            end
            pct_qued     <= w_done_fire;
            pct_len      <= w_done_fire ? r_byte_cnt : '0;
            err_oversize <= w_done_fire & r_oversize;
            if (pct_qued && !w_pend_dec && (r_pend_cnt != c_max_pkts)) begin
                r_pend_cnt <= r_pend_cnt + c_pend_w'(1);
            end else if (!pct_qued && w_pend_dec) begin
                r_pend_cnt <= r_pend_cnt - c_pend_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_payload_loader.sv
`default_nettype none
// =============================================================================
// Module   : tb_tx_payload_loader
// Brief    : Directed self-checking bench for tx_payload_loader.
// Revision : 1.0 - initial release
// =============================================================================
module tb_tx_payload_loader;

`ifdef TX_LOADER_PAD_EN
    localparam bit c_pad = 1'b1;
`else
    localparam bit c_pad = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        arst_n   = 1'b0;
    logic [7:0]  s_data   = '0;
    logic        s_valid  = 1'b0;
    logic        s_last   = 1'b0;
    logic        buf_full = 1'b0;
    logic        pct_txed = 1'b0;
    logic        s_ready;
    logic [7:0]  data_out;
    logic        buf_w_en;
    logic        pct_qued;
    logic [10:0] pct_len;
    logic        err_oversize;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tx_payload_loader dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .buf_full     (buf_full),
        .pct_txed     (pct_txed),
        .data_out     (data_out),
        .buf_w_en     (buf_w_en),
        .pct_qued     (pct_qued),
        .pct_len      (pct_len),
        .err_oversize (err_oversize)
    );

    logic [7:0]  wq[$];
    int          cyc       = 0;
    int          first_acc = -1;
    int          last_acc  = -1;
    int          first_wr  = -1;
    int          qued_cyc  = -1;
    int          acc_n     = 0;
    int          qued_n    = 0;
    int          full_viol = 0;
    logic [10:0] last_len  = '0;
    logic        last_err  = 1'b0;
    logic        prev_full = 1'b0;
    bit          tog_en    = 1'b0;
    int          tog_cnt   = 0;

    always @(negedge clk) begin
        cyc++;
        if (buf_w_en) begin
            wq.push_back(data_out);
            if (first_wr < 0) first_wr = cyc;
            if (prev_full) full_viol++;
        end
        if (s_valid && s_ready) begin
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            acc_n++;
        end
        if (pct_qued) begin
            qued_n++;
            qued_cyc = cyc;
            last_len = pct_len;
            last_err = err_oversize;
        end
        prev_full = buf_full;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog_en) begin
            tog_cnt++;
            if (tog_cnt % 3 == 0) buf_full = ~buf_full;
        end
    endtask

    task automatic clr();
        wq.delete();
        first_acc = -1;
        last_acc  = -1;
        first_wr  = -1;
        acc_n     = 0;
        full_viol = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("ready_timeout", 32'(s_ready), 32'd1);
    endtask

    task automatic send(input int total, input int from, input int stop, input int base);
        for (int i = from; i < stop; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(base + i);
            s_last  = (i == total - 1);
            wait_ready();
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_qued(input int target);
        int n = 0;
        while (qued_n < target && n < 3000) begin
            tick();
            n++;
        end
        chk("qued_count", 32'(qued_n), 32'(target));
        tick();
    endtask

    task automatic check_frame(input string tag, input int q0, input int n_data, input int base,
                               input int exp_wr, input int exp_len, input bit exp_err);
        int         bad = 0;
        logic [7:0] e;
        wait_qued(q0 + 1);
        chk({tag, "_writes"}, 32'(wq.size()), 32'(exp_wr));
        for (int i = 0; i < wq.size(); i++) begin
            e = (i < n_data) ? 8'(base + i) : 8'h00;
            if (wq[i] !== e) bad++;
        end
        chk({tag, "_order"}, 32'(bad), 32'd0);
        chk({tag, "_len"}, 32'(last_len), 32'(exp_len));
        chk({tag, "_err"}, 32'(last_err), 32'(exp_err));
    endtask

    task automatic pulse_txed();
        pct_txed = 1'b1;
        tick();
        pct_txed = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int q0;
        int l1;
        int n;

        repeat (3) tick();
        chk("rst_ctrl", 32'({s_ready, buf_w_en, pct_qued, err_oversize}), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_len", 32'(pct_len), 32'd0);
        chk("rst_pend", 32'(dut.r_pend_cnt), 32'd0);
        arst_n = 1'b1;
        tick();
        tick();

        // 60-byte payload, no stalls
        clr(); q0 = qued_n;
        send(60, 0, 60, 0);
        check_frame("a60", q0, 60, 0, 60, 60, 1'b0);
        chk("a60_wr_latency", 32'(first_wr - first_acc), 32'd1);
        chk("a60_qued_latency", 32'(qued_cyc - last_acc), 32'd2);
        chk("a60_accepted", 32'(acc_n), 32'd60);
        pulse_txed();

        // short payload: padded or passed through depending on build
        clr(); q0 = qued_n;
        send(10, 0, 10, 8'h80);
        check_frame("b10", q0, 10, 8'h80, c_pad ? 46 : 10, c_pad ? 46 : 10, 1'b0);
        pulse_txed();

        // oversize payload truncated at 1500
        clr(); q0 = qued_n;
        send(1600, 0, 1600, 0);
        check_frame("c1600", q0, 1500, 0, 1500, 1500, 1'b1);
        chk("c1600_accepted", 32'(acc_n), 32'd1600);
        pulse_txed();

        // exactly MAX_LEN bytes is a normal frame
        clr(); q0 = qued_n;
        send(1500, 0, 1500, 7);
        check_frame("d1500", q0, 1500, 7, 1500, 1500, 1'b0);
        pulse_txed();

        // two frames back to back, then a third is held off by MAX_PKTS
        clr(); q0 = qued_n;
        send(50, 0, 50, 8'h10);
        l1 = last_acc;
        first_acc = -1;
        send(50, 0, 50, 8'h20);
        chk("b2b_gap", 32'(first_acc - l1), 32'd3);
        wait_qued(q0 + 2);
        chk("b2b_writes", 32'(wq.size()), 32'd100);
        chk("pend_full", 32'(dut.r_pend_cnt), 32'd2);
        s_valid = 1'b1; s_data = 8'h30; s_last = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("held_ready", 32'(s_ready), 32'd0);
        chk("held_accepted", 32'(acc_n), 32'd100);
        tick();
        pct_txed = 1'b1;
        @(negedge clk);
        chk("txed_same_cycle_ready", 32'(s_ready), 32'd0);
        tick();
        pct_txed = 1'b0;
        @(negedge clk);
        chk("txed_next_cycle_ready", 32'(s_ready), 32'd1);
        tick();
        send(50, 1, 50, 8'h30);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pct_qued && n < 300);
        chk("sim_qued_seen", 32'(pct_qued), 32'd1);
        chk("sim_pend_before", 32'(dut.r_pend_cnt), 32'd1);
        pct_txed = 1'b1;
        tick();
        pct_txed = 1'b0;
        @(negedge clk);
        chk("sim_pend_after", 32'(dut.r_pend_cnt), 32'd1);
        chk("f3_len", 32'(last_len), 32'd50);
        chk("f3_writes", 32'(wq.size()), 32'd150);
        tick();
        pulse_txed();

        // buf_full toggling every 3 cycles
        clr(); q0 = qued_n;
        tog_cnt = 0; tog_en = 1'b1;
        send(50, 0, 50, 8'h40);
        check_frame("tog50", q0, 50, 8'h40, 50, 50, 1'b0);
        chk("tog50_full_write", 32'(full_viol), 32'd0);
        pulse_txed();
        clr(); q0 = qued_n;
        send(5, 0, 5, 8'h60);
        check_frame("tog5", q0, 5, 8'h60, c_pad ? 46 : 5, c_pad ? 46 : 5, 1'b0);
        chk("tog5_full_write", 32'(full_viol), 32'd0);
        tog_en = 1'b0;
        buf_full = 1'b0;
        tick();

        // reset at byte 20 of 100 with one frame still pending
        clr();
        send(100, 0, 20, 0);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({s_ready, buf_w_en, pct_qued, err_oversize}), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);
        chk("mid_rst_pend", 32'(dut.r_pend_cnt), 32'd0);
        tick();
        tick();
        arst_n = 1'b1;
        tick();
        clr(); q0 = qued_n;
        send(60, 0, 60, 8'h90);
        check_frame("post_rst", q0, 60, 8'h90, 60, 60, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
